// File: rtl/colour_pkg.sv
// Constants and arithmetic helpers shared by the HSV->RGB and RGB->HSV colour paths.
package colour_pkg;

    localparam int PIX_W        = 8;
    localparam int HUE_SECTOR   = 43;
    localparam int SECTOR_SCALE = 6;

    typedef logic [2:0] region_t;

    localparam region_t REGION_0 = 3'd0;
    localparam region_t REGION_1 = 3'd1;
    localparam region_t REGION_2 = 3'd2;
    localparam region_t REGION_3 = 3'd3;
    localparam region_t REGION_4 = 3'd4;
    localparam region_t REGION_5 = 3'd5;

    // Upper byte of an 8x8 product: (a*b)>>8, truncated.
    function automatic logic [PIX_W-1:0] mul_hi(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
        logic [2*PIX_W-1:0] w_prod;
        w_prod = {{PIX_W{1'b0}}, a} * {{PIX_W{1'b0}}, b};
        return w_prod[2*PIX_W-1:PIX_W];
    endfunction

endpackage

// File: rtl/hsv_sector_div.sv
// Combinational hue-sector split: region = h/43 by compare chain, rem = scaled offset in sector.
module hsv_sector_div
    import colour_pkg::*;
(
    input  logic [PIX_W-1:0] h,
    output region_t          region,
    output logic [PIX_W-1:0] rem
);

    logic [PIX_W-1:0] w_base;
    logic [PIX_W-1:0] w_off;

    always_comb begin
        region = REGION_0;
        w_base = '0;
        if (h >= PIX_W'(5 * HUE_SECTOR)) begin
            region = REGION_5;
            w_base = PIX_W'(5 * HUE_SECTOR);
        end else if (h >= PIX_W'(4 * HUE_SECTOR)) begin
            region = REGION_4;
            w_base = PIX_W'(4 * HUE_SECTOR);
        end else if (h >= PIX_W'(3 * HUE_SECTOR)) begin
            region = REGION_3;
            w_base = PIX_W'(3 * HUE_SECTOR);
        end else if (h >= PIX_W'(2 * HUE_SECTOR)) begin
            region = REGION_2;
            w_base = PIX_W'(2 * HUE_SECTOR);
        end else if (h >= PIX_W'(HUE_SECTOR)) begin
            region = REGION_1;
            w_base = PIX_W'(HUE_SECTOR);
        end
    end

    // Offset is at most 42, so the scaled value (<=252) fits in one byte.
    assign w_off = h - w_base;
    assign rem   = w_off * PIX_W'(SECTOR_SCALE);

endmodule

// File: rtl/hsv2rgb.sv
// Three-stage HSV->RGB converter with valid/ready streaming and a global stall enable.
// Optional sideband tag pipeline enabled by defining HSV2RGB_TAG_EN.
module hsv2rgb
    import colour_pkg::*;
#(
    parameter int LATENCY = 3
`ifdef HSV2RGB_TAG_EN
    , parameter int TAG_W = 2
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] h,
    input  logic [PIX_W-1:0] s,
    input  logic [PIX_W-1:0] v,
`ifdef HSV2RGB_TAG_EN
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] r,
    output logic [PIX_W-1:0] g,
    output logic [PIX_W-1:0] b
);

    logic               w_en;
    logic [LATENCY-1:0] r_vld;

    region_t          w_region;
    logic [PIX_W-1:0] w_rem;
    region_t          r1_region;
    logic [PIX_W-1:0] r1_rem;
    logic [PIX_W-1:0] r1_s;
    logic [PIX_W-1:0] r1_v;
    logic             r1_grey;

    region_t          r2_region;
    logic [PIX_W-1:0] r2_v;
    logic [PIX_W-1:0] r2_p;
    logic [PIX_W-1:0] r2_sr;
    logic [PIX_W-1:0] r2_st;
    logic             r2_grey;

    logic [PIX_W-1:0] w_q;
    logic [PIX_W-1:0] w_t;
    logic [PIX_W-1:0] w_r;
    logic [PIX_W-1:0] w_g;
    logic [PIX_W-1:0] w_b;

    assign out_valid = r_vld[LATENCY-1];
    assign w_en      = !out_valid || out_ready;
    assign in_ready  = w_en;

    hsv_sector_div u_sector (
        .h      (h),
        .region (w_region),
        .rem    (w_rem)
    );

    // For 8-bit operands ~x is exactly 255-x.
    assign w_q = mul_hi(r2_v, ~r2_sr);
    assign w_t = mul_hi(r2_v, ~r2_st);

    always_comb begin
        w_r = r2_v;
        w_g = r2_v;
        w_b = r2_v;
        if (!r2_grey) begin
            unique case (r2_region)
                REGION_0: begin w_r = r2_v; w_g = w_t;  w_b = r2_p; end
                REGION_1: begin w_r = w_q;  w_g = r2_v; w_b = r2_p; end
                REGION_2: begin w_r = r2_p; w_g = r2_v; w_b = w_t;  end
                REGION_3: begin w_r = r2_p; w_g = w_q;  w_b = r2_v; end
                REGION_4: begin w_r = w_t;  w_g = r2_p; w_b = r2_v; end
                default:  begin w_r = r2_v; w_g = r2_p; w_b = w_q;  end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld     <= '0;
            r1_region <= REGION_0;
            r1_rem    <= '0;
            r1_s      <= '0;
            r1_v      <= '0;
            r1_grey   <= 1'b0;
            r2_region <= REGION_0;
            r2_v      <= '0;
            r2_p      <= '0;
            r2_sr     <= '0;
            r2_st     <= '0;
            r2_grey   <= 1'b0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
        end else if (w_en) begin
            r_vld     <= {r_vld[LATENCY-2:0], in_valid};
            r1_region <= w_region;
            r1_rem    <= w_rem;
            r1_s      <= s;
            r1_v      <= v;
            r1_grey   <= (s == '0);
            r2_region <= r1_region;
            r2_v      <= r1_v;
            r2_p      <= mul_hi(r1_v, ~r1_s);
            r2_sr     <= mul_hi(r1_s, r1_rem);
            r2_st     <= mul_hi(r1_s, ~r1_rem);
            r2_grey   <= r1_grey;
            r         <= w_r;
            g         <= w_g;
            b         <= w_b;
        end
    end

`ifdef HSV2RGB_TAG_EN
    logic [TAG_W-1:0] r_tag [LATENCY];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
        end else if (w_en) begin
            r_tag[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign out_tag = r_tag[LATENCY-1];
`endif

endmodule

// File: tb/tb_hsv2rgb.sv
// Scoreboard bench for hsv2rgb: directed colours, latency, streaming, stall, reset and random traffic.
module tb_hsv2rgb;

`ifdef HSV2RGB_TAG_EN
    localparam int TAG_MASK = 3;
`else
    localparam int TAG_MASK = 0;
`endif

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] h = '0, s = '0, v = '0;
    logic       in_ready, out_valid;
    logic [7:0] r, g, b;
`ifdef HSV2RGB_TAG_EN
    logic [1:0] in_tag = '0;
    logic [1:0] out_tag;
`endif

    int          n_vec   = 0;
    int          n_err   = 0;
    int          run_len = 0;
    int          max_run = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_px;

    always #5 clock = ~clock;

    hsv2rgb dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .h         (h),
        .s         (s),
        .v         (v),
`ifdef HSV2RGB_TAG_EN
        .in_tag    (in_tag),
        .out_tag   (out_tag),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .g         (g),
        .b         (b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input int hh, input int ss, input int vv, input int tg);
        int rg, rem, p, sr, st, q, t, ro, go, bo;
        if (ss == 0) begin
            ro = vv; go = vv; bo = vv;
        end else begin
            rg  = hh / 43;
            rem = ((hh - 43 * rg) * 6) % 256;
            p   = vv * (255 - ss) / 256;
            sr  = ss * rem / 256;
            st  = ss * (255 - rem) / 256;
            q   = vv * (255 - sr) / 256;
            t   = vv * (255 - st) / 256;
            case (rg)
                0:       begin ro = vv; go = t;  bo = p;  end
                1:       begin ro = q;  go = vv; bo = p;  end
                2:       begin ro = p;  go = vv; bo = t;  end
                3:       begin ro = p;  go = q;  bo = vv; end
                4:       begin ro = t;  go = p;  bo = vv; end
                default: begin ro = vv; go = p;  bo = q;  end
            endcase
        end
        return {tg[7:0], ro[7:0], go[7:0], bo[7:0]};
    endfunction

    function automatic logic [31:0] observed();
`ifdef HSV2RGB_TAG_EN
        return {6'b0, out_tag, r, g, b};
`else
        return {8'b0, r, g, b};
`endif
    endfunction

    task automatic drive(input logic vld, input logic rdy, input logic [7:0] hh,
                         input logic [7:0] ss, input logic [7:0] vv, input logic [1:0] tg,
                         output logic acc);
        @(negedge clock);
        in_valid  = vld;
        out_ready = rdy;
        h = hh;
        s = ss;
        v = vv;
`ifdef HSV2RGB_TAG_EN
        in_tag = tg;
`endif
        #1;
        acc = reset_n && vld && in_ready;
        if (acc) sb.push_back(model(hh, ss, vv, int'(tg) & TAG_MASK));
    endtask

    task automatic idle();
        logic acc;
        drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, acc);
    endtask

    task automatic single(input string tag, input logic [7:0] hh, input logic [7:0] ss,
                          input logic [7:0] vv, input logic [23:0] exp);
        logic acc;
        int   cnt;
        drive(1'b1, 1'b1, hh, ss, vv, 2'd1, acc);
        check({tag, "_accept"}, 32'(acc), 32'd1);
        cnt = 0;
        do begin
            idle();
            cnt++;
        end while (!out_valid && cnt < 10);
        check({tag, "_latency"}, 32'(cnt), 32'd3);
        check({tag, "_rgb"}, 32'({r, g, b}), 32'(exp));
    endtask

    // Output monitor: pops the scoreboard on every output transfer.
    always begin
        @(negedge clock);
        #2;
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_px = sb.pop_front();
                check("pixel", observed(), exp_px);
            end
            run_len++;
        end else begin
            run_len = 0;
        end
        if (run_len > max_run) max_run = run_len;
    end

    initial begin
        logic        acc;
        logic [31:0] held;
        logic [7:0]  ph, ps, pv;
        logic [1:0]  pt;
        int          k;
        logic [7:0]  hb [12];
        hb = '{8'd0, 8'd42, 8'd43, 8'd85, 8'd86, 8'd128,
               8'd129, 8'd171, 8'd172, 8'd214, 8'd215, 8'd255};

        repeat (3) @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rgb", 32'({r, g, b}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef HSV2RGB_TAG_EN
        check("rst_tag", 32'(out_tag), 32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;

        single("red", 8'd0, 8'd255, 8'd255, 24'hff0000);
        single("h85", 8'd85, 8'd255, 8'd255, 24'h03ff00);
        single("h171", 8'd171, 8'd255, 8'd255, 24'h0003ff);
        single("grey", 8'd200, 8'd0, 8'd128, 24'h808080);

        // Back-to-back stream of 8 pixels
        idle();
        max_run = 0;
        for (int i = 0; i < 8; i++)
            drive(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), acc);
        repeat (6) idle();
        check("stream_run", 32'(max_run), 32'd8);

        // Stall mid-stream for 5 cycles
        k  = 0;
        ph = 8'($urandom); ps = 8'($urandom); pv = 8'($urandom); pt = 2'($urandom);
        held = '0;
        for (int i = 0; i < 20; i++) begin
            drive(k < 12, !(i >= 6 && i <= 10), ph, ps, pv, pt, acc);
            if (i >= 6 && i <= 10) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_valid", 32'(out_valid), 32'd1);
            end
            if (i == 6) held = observed();
            if (i >= 7 && i <= 10) check("stall_hold", observed(), held);
            if (acc) begin
                k++;
                ph = 8'($urandom); ps = 8'($urandom); pv = 8'($urandom); pt = 2'($urandom);
            end
        end
        repeat (8) idle();
        check("pre_reset_empty", 32'(sb.size()), 32'd0);

        // Reset with three pixels in flight
        drive(1'b1, 1'b1, 8'd0, 8'd255, 8'd255, 2'd2, acc);
        drive(1'b1, 1'b1, 8'd60, 8'd200, 8'd180, 2'd3, acc);
        drive(1'b1, 1'b1, 8'd140, 8'd90, 8'd220, 2'd1, acc);
        @(posedge clock);
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flight_rst_valid", 32'(out_valid), 32'd0);
        check("flight_rst_rgb", 32'({r, g, b}), 32'd0);
`ifdef HSV2RGB_TAG_EN
        check("flight_rst_tag", 32'(out_tag), 32'd0);
`endif
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        check("flight_rst_hold", 32'(out_valid), 32'd0);
        reset_n = 1'b1;
        single("post_rst", 8'd43, 8'd255, 8'd255, 24'hfeff00);

        // Sector boundaries at full and minimal saturation
        foreach (hb[i]) begin
            drive(1'b1, 1'b1, hb[i], 8'd255, 8'd255, 2'($urandom), acc);
            drive(1'b1, 1'b1, hb[i], 8'd1, 8'd200, 2'($urandom), acc);
        end

        // Random traffic with random bubbles and backpressure
        for (int i = 0; i < 400; i++) begin
            ps = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            pv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                  8'($urandom), ps, pv, 2'($urandom), acc);
        end

        k = 0;
        while (sb.size() != 0 && k < 30) begin
            idle();
            k++;
        end
        idle();
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
